// File: rtl/nbit_arith_pkg.sv
// Shared definitions for the n-bit arithmetic blocks (multiplier and divider):
// default operand width, divider state encoding and a width helper.
package nbit_arith_pkg;

  // Operand width shared by the registered multiplier and the sequential divider.
  localparam int N_DEFAULT = 5;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Number of bits needed to count 0 .. value-1 (ceil(log2(value))), minimum 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/nbit_seq_divider_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits. Purely combinational.
module div_step
  import nbit_arith_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N:0]   r_in,
  input  logic         next_bit,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_out,
  output logic         q_bit
);

  logic [N+1:0] shifted;
  logic [N+1:0] dsr_ext;

  // Shift-in, trial compare and conditional subtract for one quotient bit.
  always_comb begin
    shifted = {r_in, next_bit};
    dsr_ext = {2'b00, divisor};
    if (shifted >= dsr_ext) begin
      r_out = (N+1)'(shifted - dsr_ext);
      q_bit = 1'b1;
    end else begin
      r_out = shifted[N:0];
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/nbit_seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, start/done handshake. The dividend register doubles as the
// quotient register: each step shifts out a dividend bit and shifts in a
// quotient bit, so after 2N steps it holds the full quotient.
module nbit_seq_divider
  import nbit_arith_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int W2 = 2 * N;
  localparam int CW = clog2(W2);
  localparam logic [CW-1:0] LAST_STEP = CW'(W2 - 1);

  div_state_t state;
  div_state_t state_nxt;

  logic [N:0]    r;
  logic [N:0]    r_nxt;
  logic [W2-1:0] dvd;
  logic [W2-1:0] dvd_nxt;
  logic [N-1:0]  dsr;
  logic [N-1:0]  dsr_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [W2-1:0] quo_nxt;
  logic [N-1:0]  rem_nxt;
  logic          dbz_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  logic [N:0]    step_r;
  logic          step_q;

  div_step #(.N(N)) u_step (
    .r_in     (r),
    .next_bit (dvd[W2-1]),
    .divisor  (dsr),
    .r_out    (step_r),
    .q_bit    (step_q)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, working-register and output-register next values.
  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    dvd_nxt   = dvd;
    dsr_nxt   = dsr;
    cnt_nxt   = cnt;
    quo_nxt   = quotient;
    rem_nxt   = remainder;
    dbz_nxt   = div_by_zero;
    case (state)
      ST_IDLE: begin
        if (start) begin
          dvd_nxt = dividend;
          dsr_nxt = divisor;
          r_nxt   = '0;
          cnt_nxt = '0;
          if (divisor == {N{1'b0}}) begin
            // No iteration: results are fixed and published on the DONE cycle.
            state_nxt = ST_DONE;
            quo_nxt   = '1;
            rem_nxt   = '0;
            dbz_nxt   = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        r_nxt   = step_r;
        dvd_nxt = {dvd[W2-2:0], step_q};
        if (cnt == LAST_STEP) begin
          state_nxt = ST_DONE;
          cnt_nxt   = cnt;
          quo_nxt   = {dvd[W2-2:0], step_q};
          rem_nxt   = step_r[N-1:0];
          dbz_nxt   = 1'b0;
        end else begin
          state_nxt = ST_RUN;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
  end

  // Working registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= '0;
      dvd         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r           <= r_nxt;
      dvd         <= dvd_nxt;
      dsr         <= dsr_nxt;
      cnt         <= cnt_nxt;
      quotient    <= quo_nxt;
      remainder   <= rem_nxt;
      div_by_zero <= dbz_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_nbit_seq_divider.sv
// Self-checking bench for nbit_seq_divider: directed vector table, multi-cycle
// corner sequences, and randomized divides against plain-arithmetic reference.
module tb_nbit_seq_divider;

  localparam int N       = 5;
  localparam int W2      = 2 * N;
  localparam int TIMEOUT = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W2-1:0] dividend;
  logic [N-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W2-1:0] quotient;
  logic [N-1:0]  remainder;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  nbit_seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dvd;
    int dsr;
    int q;
    int r;
    int dbz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, divide-by-zero gives all-ones quotient.
  task automatic ref_div(input int a, input int b, output int q, output int r, output int dbz);
    if (b == 0) begin
      q = (1 << W2) - 1; r = 0; dbz = 1;
    end else begin
      q = a / b; r = a % b; dbz = 0;
    end
  endtask

  // From the current negedge, step negedges until done (bounded).
  // n = extra negedges taken; bc = cycles seen with busy high, done cycle included.
  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (1) begin
      if (busy === 1'b1) bc++;
      if (done === 1'b1 || n >= TIMEOUT) break;
      @(negedge clk);
      n++;
    end
  endtask

  // One full transaction with latency, busy window, results and hold checks.
  task automatic run_div(input string tag, input int a, input int b,
                         input int eq, input int er, input int edbz);
    int n, bc, lat_exp;
    @(negedge clk);
    dividend = W2'(a);
    divisor  = N'(b);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    lat_exp = (b == 0) ? 1 : W2 + 1;
    check({tag, " latency"}, n + 1, lat_exp);
    check({tag, " busy_cycles"}, bc, lat_exp);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, edbz);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " busy_after"}, busy, 0);
    check({tag, " quotient_hold"}, quotient, eq);
  endtask

  initial begin
    vec_t tbl[9];
    int n, bc, m;
    int a, b, c, q, r, dbz;

    tbl[0] = '{dvd: 25,   dsr: 7,  q: 3,    r: 4, dbz: 0};
    tbl[1] = '{dvd: 1023, dsr: 31, q: 33,   r: 0, dbz: 0};
    tbl[2] = '{dvd: 899,  dsr: 31, q: 29,   r: 0, dbz: 0};
    tbl[3] = '{dvd: 100,  dsr: 0,  q: 1023, r: 0, dbz: 1};
    tbl[4] = '{dvd: 30,   dsr: 4,  q: 7,    r: 2, dbz: 0};
    tbl[5] = '{dvd: 0,    dsr: 5,  q: 0,    r: 0, dbz: 0};
    tbl[6] = '{dvd: 1023, dsr: 1,  q: 1023, r: 0, dbz: 0};
    tbl[7] = '{dvd: 6,    dsr: 31, q: 0,    r: 6, dbz: 0};
    tbl[8] = '{dvd: 1000, dsr: 30, q: 33,   r: 10, dbz: 0};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", busy, 0);
    check("idle quotient", quotient, 0);

    for (int i = 0; i < 9; i++) begin
      run_div($sformatf("vec%0d", i), tbl[i].dvd, tbl[i].dsr, tbl[i].q, tbl[i].r, tbl[i].dbz);
    end

    // Start held during RUN is ignored; second op accepted right after DONE.
    @(negedge clk);
    dividend = W2'(40); divisor = N'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    dividend = W2'(7); divisor = N'(2); start = 1'b1;
    check("b2b quotient_not_cleared", quotient, 33);
    wait_done(n, bc);
    check("b2b first_quotient", quotient, 13);
    check("b2b first_remainder", remainder, 1);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (done !== 1'b1 && m < TIMEOUT);
    start = 1'b0;
    check("b2b second_latency", m, 12);
    check("b2b second_quotient", quotient, 3);
    check("b2b second_remainder", remainder, 1);
    @(negedge clk);
    check("b2b no_third", busy, 0);

    // Asynchronous reset in RUN cycle 4, then a normal divide.
    @(negedge clk);
    dividend = W2'(100); divisor = N'(7); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    check("midrst div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    run_div("rst_recover", 30, 4, 7, 2, 0);

    // Round trip with the multiplier: (a*b + c) / b == a rem c.
    for (int t = 0; t < 1000; t++) begin
      a = int'($urandom_range(31, 1));
      b = int'($urandom_range(31, 1));
      c = int'($urandom_range(b - 1, 0));
      run_div("roundtrip", a * b + c, b, a, c, 0);
    end

    // Unconstrained operands, including zero divisor, against the reference.
    for (int t = 0; t < 150; t++) begin
      a = int'($urandom_range(1023, 0));
      b = int'($urandom_range(31, 0));
      ref_div(a, b, q, r, dbz);
      run_div("random", a, b, q, r, dbz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
